plab4_net_router_input_buf_dual: RTL and testbench

Per-port, two-domain input buffer placed directly upstream of the router input-control arbiter. It accepts one incoming network link whose messages carry a 1-bit security-domain tag and steers each message into a private per-domain FIFO, so a stalled domain never blocks the other. It presents each queue's head message, destination field and valid bit to the arbiter, and dequeues on that arbiter's per-domain ready.

---
 rtl/plab4_net_router_input_buf_dual.sv | 110 +++++++++++
 tb/tb_plab4_net_router_input_buf_dual.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_input_buf_dual.sv
// Two-domain router input buffer: steers each incoming message into a private
// per-domain FIFO by its domain tag and exposes both queue heads to the arbiter.
module plab4_net_router_input_buf_dual #(
  parameter int unsigned p_router_id   = 0,
  parameter int unsigned p_num_routers = 8,
  parameter int unsigned p_msg_nbits   = 44,
  parameter int unsigned p_num_entries = 2,

  localparam int unsigned c_dest_nbits = $clog2(p_num_routers),
  localparam int unsigned c_ptr_nbits  = $clog2(p_num_entries),
  localparam int unsigned c_cnt_nbits  = c_ptr_nbits + 1
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [p_msg_nbits-1:0]  in_msg,
  input  logic                    in_domain,

  output logic                    deq_val_d1,
  input  logic                    deq_rdy_d1,
  output logic [p_msg_nbits-1:0]  deq_msg_d1,
  output logic [c_dest_nbits-1:0] dest_d1,
  output logic [c_cnt_nbits-1:0]  num_free_d1,

  output logic                    deq_val_d2,
  input  logic                    deq_rdy_d2,
  output logic [p_msg_nbits-1:0]  deq_msg_d2,
  output logic [c_dest_nbits-1:0] dest_d2,
  output logic [c_cnt_nbits-1:0]  num_free_d2
);

  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);

  // Pointers wrap naturally, so the depth must be a power of two.
  if ((p_num_entries < 2) || ((p_num_entries & (p_num_entries - 1)) != 0) ||
      (p_router_id >= p_num_routers)) begin : g_param_check
    $fatal(1, "plab4_net_router_input_buf_dual: illegal parameter set");
  end

  logic [1:0]             deq_rdy_w;
  logic [1:0]             not_full;
  logic [1:0]             enq_go;
  logic [1:0]             deq_go;
  logic [1:0]             val_w;
  logic [p_msg_nbits-1:0] head_w [2];
  logic [c_cnt_nbits-1:0] free_w [2];

  assign deq_rdy_w = {deq_rdy_d2, deq_rdy_d1};

  // Acceptance looks only at the tagged queue's occupancy: no pop-to-push bypass.
  assign in_rdy = not_full[in_domain];

  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic [c_ptr_nbits-1:0] enq_ptr_q, enq_ptr_d;
    logic [c_ptr_nbits-1:0] deq_ptr_q, deq_ptr_d;
    logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
    logic [p_msg_nbits-1:0] mem_q [p_num_entries];

    assign not_full[d] = (cnt_q != c_full);
    assign val_w[d]    = (cnt_q != '0);
    assign enq_go[d]   = in_val && not_full[d] && (in_domain == 1'(d));
    assign deq_go[d]   = val_w[d] && deq_rdy_w[d];

    always_comb begin
      enq_ptr_d = enq_ptr_q;
      deq_ptr_d = deq_ptr_q;
      cnt_d     = cnt_q;
      if (enq_go[d]) enq_ptr_d = enq_ptr_q + 1'b1;
      if (deq_go[d]) deq_ptr_d = deq_ptr_q + 1'b1;
      unique case ({enq_go[d], deq_go[d]})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        enq_ptr_q <= '0;
        deq_ptr_q <= '0;
        cnt_q     <= '0;
      end else begin
        enq_ptr_q <= enq_ptr_d;
        deq_ptr_q <= deq_ptr_d;
        cnt_q     <= cnt_d;
      end
    end

    // Storage is deliberately not reset; a cleared count hides stale entries.
    always_ff @(posedge clk) begin
      if (enq_go[d]) mem_q[enq_ptr_q] <= in_msg;
    end

    assign head_w[d] = mem_q[deq_ptr_q];
    assign free_w[d] = c_full - cnt_q;
  end

  assign deq_val_d1  = val_w[0];
  assign deq_msg_d1  = head_w[0];
  assign dest_d1     = head_w[0][p_msg_nbits-1 -: c_dest_nbits];
  assign num_free_d1 = free_w[0];

  assign deq_val_d2  = val_w[1];
  assign deq_msg_d2  = head_w[1];
  assign dest_d2     = head_w[1][p_msg_nbits-1 -: c_dest_nbits];
  assign num_free_d2 = free_w[1];

endmodule

// File: tb/tb_plab4_net_router_input_buf_dual.sv
// Scoreboard bench for the two-domain router input buffer (depth 2, 44-bit msgs).
module tb_plab4_net_router_input_buf_dual;

  localparam int unsigned MSG_W = 44;
  localparam int unsigned DEST_W = 3;
  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_val;
  logic              in_rdy;
  logic [MSG_W-1:0]  in_msg;
  logic              in_domain;
  logic              deq_val_d1, deq_rdy_d1, deq_val_d2, deq_rdy_d2;
  logic [MSG_W-1:0]  deq_msg_d1, deq_msg_d2;
  logic [DEST_W-1:0] dest_d1, dest_d2;
  logic [1:0]        num_free_d1, num_free_d2;

  plab4_net_router_input_buf_dual #(
    .p_router_id   (0),
    .p_num_routers (8),
    .p_msg_nbits   (MSG_W),
    .p_num_entries (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_msg      (in_msg),
    .in_domain   (in_domain),
    .deq_val_d1  (deq_val_d1),
    .deq_rdy_d1  (deq_rdy_d1),
    .deq_msg_d1  (deq_msg_d1),
    .dest_d1     (dest_d1),
    .num_free_d1 (num_free_d1),
    .deq_val_d2  (deq_val_d2),
    .deq_rdy_d2  (deq_rdy_d2),
    .deq_msg_d2  (deq_msg_d2),
    .dest_d2     (dest_d2),
    .num_free_d2 (num_free_d2)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [MSG_W-1:0] sb_q1 [$];
  logic [MSG_W-1:0] sb_q2 [$];
  logic last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check against the scoreboard, then cross the edge.
  task automatic step(input logic v, input logic dom, input logic [MSG_W-1:0] msg,
                      input logic r1, input logic r2);
    logic             exp_rdy;
    logic [MSG_W-1:0] h;
    int unsigned      n1, n2;
    in_val = v; in_domain = dom; in_msg = msg; deq_rdy_d1 = r1; deq_rdy_d2 = r2;
    #1;
    n1 = sb_q1.size();
    n2 = sb_q2.size();
    exp_rdy = dom ? (n2 != DEPTH) : (n1 != DEPTH);
    check("in_rdy", in_rdy, exp_rdy);
    check("deq_val_d1", deq_val_d1, n1 != 0);
    check("deq_val_d2", deq_val_d2, n2 != 0);
    check("num_free_d1", num_free_d1, 64'(DEPTH - n1));
    check("num_free_d2", num_free_d2, 64'(DEPTH - n2));
    if (n1 != 0) begin
      h = r1 ? sb_q1.pop_front() : sb_q1[0];
      check("deq_msg_d1", deq_msg_d1, h);
      check("dest_d1", dest_d1, h[MSG_W-1 -: DEST_W]);
    end
    if (n2 != 0) begin
      h = r2 ? sb_q2.pop_front() : sb_q2[0];
      check("deq_msg_d2", deq_msg_d2, h);
      check("dest_d2", dest_d2, h[MSG_W-1 -: DEST_W]);
    end
    last_acc = v && exp_rdy;
    if (last_acc) begin
      if (dom) sb_q2.push_back(msg);
      else     sb_q1.push_back(msg);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    in_domain = 1'b0; #1;
    check("rst_in_rdy_dom0", in_rdy, 1'b1);
    in_domain = 1'b1; #1;
    check("rst_in_rdy_dom1", in_rdy, 1'b1);
    check("rst_deq_val_d1", deq_val_d1, 1'b0);
    check("rst_deq_val_d2", deq_val_d2, 1'b0);
    check("rst_num_free_d1", num_free_d1, 2);
    check("rst_num_free_d2", num_free_d2, 2);
  endtask

  initial begin
    logic [63:0]      rnd;
    logic             v, dom;
    logic [MSG_W-1:0] msg;
    reset = 1'b1; in_val = 1'b0; in_domain = 1'b0; in_msg = '0;
    deq_rdy_d1 = 1'b0; deq_rdy_d2 = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    reset = 1'b0;

    // Single enqueue into domain1, visible after one edge.
    step(1'b1, 1'b0, 44'hA00_0000_0001, 1'b0, 1'b0);
    #1;
    check("first_dest_d1", dest_d1, 5);
    check("first_num_free_d1", num_free_d1, 1);
    check("first_deq_val_d2", deq_val_d2, 1'b0);

    // Fill domain1, then domain2 still accepts.
    step(1'b1, 1'b0, 44'h300_0000_0002, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 44'hE00_0000_0003, 1'b0, 1'b0);

    // Full domain1 popped and pushed in one cycle: pop only, accept next cycle.
    step(1'b1, 1'b0, 44'h700_0000_0004, 1'b1, 1'b0);
    step(1'b1, 1'b0, 44'h700_0000_0004, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Stream six messages through domain2 across the pointer wrap.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, MSG_W'(64'h100_0000_0010 + 64'(i) * 64'h200_0000_0001), 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, '0, 1'b0, 1'b1);

    // Random interleaving; a refused message is held until accepted.
    last_acc = 1'b1; v = 1'b0; dom = 1'b0; msg = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !last_acc)) begin
        v   = 1'($urandom_range(0, 3) != 0);
        dom = 1'($urandom_range(0, 1));
        rnd = {$urandom, $urandom};
        msg = rnd[MSG_W-1:0];
      end
      step(v, dom, msg, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    // Mid-traffic asynchronous reset with a handshake attempted under reset.
    step(1'b1, 1'b0, 44'h200_0000_00AA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 44'h400_0000_00BB, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    sb_q1.delete();
    sb_q2.delete();
    check_reset_state();
    in_val = 1'b1; in_domain = 1'b0; deq_rdy_d1 = 1'b1; deq_rdy_d2 = 1'b1;
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 44'hC00_0000_00CC, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
